// File: rtl/ctrl_spi_bank_if.sv
`default_nettype none
// ============================================================================
// ctrl_spi_bank_if : SPI pins plus channel outputs and frame status strobes
// Revision: 1.0
// ============================================================================
interface ctrl_spi_bank_if #(
  parameter int N_CH      = 8,
  parameter int DATA_BITS = 8
);
  logic                      ctrl_sclk;
  logic                      ctrl_mosi;
  logic                      ctrl_ss_n;
  logic [N_CH*DATA_BITS-1:0] ctrl_out;
  logic [N_CH-1:0]           ctrl_upd;
  logic                      frame_ok;
  logic                      frame_err;

  modport master (
    output ctrl_sclk, ctrl_mosi, ctrl_ss_n,
    input  ctrl_out, ctrl_upd, frame_ok, frame_err
  );

  modport slave (
    input  ctrl_sclk, ctrl_mosi, ctrl_ss_n,
    output ctrl_out, ctrl_upd, frame_ok, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_spi_bank.sv
`default_nettype none
// ============================================================================
// ctrl_spi_bank : SPI slave control bank with per-channel slew-limited outputs
// Revision: 1.0
// ============================================================================
module ctrl_spi_bank #(
  parameter int                   N_CH      = 8,
  parameter int                   ADDR_BITS = 8,
  parameter int                   DATA_BITS = 8,
  parameter logic [DATA_BITS-1:0] RESET_VAL = 8'h80,
  parameter int                   TICK_DIV  = 50000,
  parameter int                   SLEW_STEP = 4
) (
  input  logic           clk,
  input  logic           reset,
  ctrl_spi_bank_if.slave bus
);
  localparam int FRAME  = ADDR_BITS + DATA_BITS;
  localparam int BCNT_W = $clog2(FRAME + 2);
  localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [BCNT_W-1:0]    FRAME_CNT = BCNT_W'(FRAME);
  localparam logic [BCNT_W-1:0]    SAT_CNT   = BCNT_W'(FRAME + 1);
  localparam logic [TCNT_W-1:0]    TICK_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_BITS:0]   N_CH_W    = (ADDR_BITS + 1)'(N_CH);
  localparam logic [DATA_BITS:0]   STEP_W    = (DATA_BITS + 1)'(SLEW_STEP);
  localparam logic [DATA_BITS-1:0] STEP_D    = DATA_BITS'(SLEW_STEP);
  localparam bit                   BYPASS    = (SLEW_STEP == 0);

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // Bits [1:0] are the synchroniser, bit [2] is the edge-detect stage.
  logic [2:0] r_sclk_sync, r_ss_sync;
  logic [1:0] r_mosi_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], bus.ctrl_sclk};
      r_ss_sync   <= {r_ss_sync[1:0], bus.ctrl_ss_n};
      r_mosi_sync <= {r_mosi_sync[0], bus.ctrl_mosi};
    end
  end

  logic w_sclk_rise, w_ss_rise, w_ss_fall, w_ss_lvl, w_mosi;
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
  assign w_ss_lvl    = r_ss_sync[1];
  assign w_mosi      = r_mosi_sync[1];

  logic w_clr, w_shift_en, w_eval;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_WAIT_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ss_n rising takes priority over a coincident sclk edge.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift_en  = 1'b0;
    w_eval      = 1'b0;
    case (r_state)
      ST_WAIT_IDLE: if (w_ss_lvl) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_ss_rise) begin
          w_eval      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise) begin
          w_shift_en  = 1'b1;
        end
      end
      default: w_state_nxt = ST_WAIT_IDLE;
    endcase
  end

  logic [FRAME-1:0]  r_shift;
  logic [BCNT_W-1:0] r_bcnt;

  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_shift <= '0;
      r_bcnt  <= '0;
    end else if (w_shift_en) begin
      r_shift <= {r_shift[FRAME-2:0], w_mosi};
      if (r_bcnt != SAT_CNT) r_bcnt <= r_bcnt + 1'b1;
    end
  end

  logic [ADDR_BITS-1:0] w_addr;
  logic [DATA_BITS-1:0] w_data;
  logic                 w_valid, w_wr_en;
  assign w_addr  = r_shift[FRAME-1 -: ADDR_BITS];
  assign w_data  = r_shift[DATA_BITS-1:0];
  assign w_valid = (r_bcnt == FRAME_CNT) && ({1'b0, w_addr} < N_CH_W);
  assign w_wr_en = w_eval & w_valid;

  logic r_frame_ok, r_frame_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_ok  <= w_wr_en;
      r_frame_err <= w_eval & ~w_valid;
    end
  end
  assign bus.frame_ok  = r_frame_ok;
  assign bus.frame_err = r_frame_err;

  logic [TCNT_W-1:0] r_tcnt;
  logic              w_tick, w_apply;
  assign w_tick  = (r_tcnt == TICK_LAST);
  assign w_apply = BYPASS ? 1'b1 : w_tick;

  always_ff @(posedge clk) begin
    if (reset || w_tick) r_tcnt <= '0;
    else                 r_tcnt <= r_tcnt + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DATA_BITS-1:0] r_tgt, r_out, w_slew, w_next;
    logic [DATA_BITS:0]   w_diff;
    logic                 w_gt, r_upd;

    always_ff @(posedge clk) begin
      if (reset)                                       r_tgt <= RESET_VAL;
      else if (w_wr_en && (w_addr == ADDR_BITS'(i)))   r_tgt <= w_data;
    end

    // Step only when the remaining distance exceeds the step, so no wrap.
    always_comb begin
      w_gt   = (r_tgt > r_out);
      w_diff = w_gt ? ({1'b0, r_tgt} - {1'b0, r_out})
                    : ({1'b0, r_out} - {1'b0, r_tgt});
      if (w_diff <= STEP_W) w_slew = r_tgt;
      else if (w_gt)        w_slew = r_out + STEP_D;
      else                  w_slew = r_out - STEP_D;
      w_next = BYPASS ? r_tgt : w_slew;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_out <= RESET_VAL;
        r_upd <= 1'b0;
      end else if (w_apply) begin
        r_out <= w_next;
        r_upd <= (w_next != r_out);
      end else begin
        r_upd <= 1'b0;
      end
    end

    assign bus.ctrl_out[i*DATA_BITS +: DATA_BITS] = r_out;
    assign bus.ctrl_upd[i]                        = r_upd;
  end
endmodule
`default_nettype wire

// File: tb/tb_ctrl_spi_bank.sv
`default_nettype none
// ============================================================================
// tb_ctrl_spi_bank : bypass and slewing instances fed identical SPI traffic
// Revision: 1.0
// ============================================================================
module tb_ctrl_spi_bank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic ss_n = 1'b1;

  always #5 clk = ~clk;

  ctrl_spi_bank_if #(.N_CH(8), .DATA_BITS(8)) bus_b ();
  ctrl_spi_bank_if #(.N_CH(8), .DATA_BITS(8)) bus_s ();

  assign bus_b.ctrl_sclk = sclk;
  assign bus_b.ctrl_mosi = mosi;
  assign bus_b.ctrl_ss_n = ss_n;
  assign bus_s.ctrl_sclk = sclk;
  assign bus_s.ctrl_mosi = mosi;
  assign bus_s.ctrl_ss_n = ss_n;

  ctrl_spi_bank #(.N_CH(8), .ADDR_BITS(8), .DATA_BITS(8), .RESET_VAL(8'h80),
                  .TICK_DIV(10), .SLEW_STEP(0))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  ctrl_spi_bank #(.N_CH(8), .ADDR_BITS(8), .DATA_BITS(8), .RESET_VAL(8'h80),
                  .TICK_DIV(10), .SLEW_STEP(4))
    dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  int passes = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [15:0] q_upd_b[$];
  logic [15:0] q_upd_s[$];
  logic [1:0]  q_frm_b[$];
  logic [1:0]  q_frm_s[$];
  int          upd0_cyc[$];
  int          upd_cyc_b[8];
  int          ok_cyc_b = 0;
  int          frm_cnt_b = 0;
  int          frm_cnt_s = 0;
  logic [7:0]  exp_tgt[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  // Pops an expectation for every strobe the DUTs produce.
  always @(negedge clk) begin
    logic [15:0] e;
    logic [1:0]  f;
    if (!reset) begin
      for (int c = 0; c < 8; c++) begin
        if (bus_b.ctrl_upd[c]) begin
          e = (q_upd_b.size() != 0) ? q_upd_b.pop_front() : 16'hFFFF;
          chk("upd_b", {c[7:0], bus_b.ctrl_out[c*8 +: 8]}, e);
          upd_cyc_b[c] = cyc;
        end
        if (bus_s.ctrl_upd[c]) begin
          e = (q_upd_s.size() != 0) ? q_upd_s.pop_front() : 16'hFFFF;
          chk("upd_s", {c[7:0], bus_s.ctrl_out[c*8 +: 8]}, e);
          if (c == 0) upd0_cyc.push_back(cyc);
        end
      end
      if (bus_b.frame_ok || bus_b.frame_err) begin
        f = (q_frm_b.size() != 0) ? q_frm_b.pop_front() : 2'b00;
        chk("frame_b", {bus_b.frame_ok, bus_b.frame_err}, f);
        frm_cnt_b++;
        if (bus_b.frame_ok) ok_cyc_b = cyc;
      end
      if (bus_s.frame_ok || bus_s.frame_err) begin
        f = (q_frm_s.size() != 0) ? q_frm_s.pop_front() : 2'b00;
        chk("frame_s", {bus_s.frame_ok, bus_s.frame_err}, f);
        frm_cnt_s++;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bits(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      mosi = bits[k];
      wait_clk(5);
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n);
    ss_n = 1'b0;
    wait_clk(5);
    clk_bits(bits, n);
    wait_clk(5);
    ss_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic push_upd(input logic [7:0] ch, input logic [7:0] from, input logic [7:0] to);
    logic [7:0] v;
    v = from;
    if (from != to) q_upd_b.push_back({ch, to});
    while (v != to) begin
      if (to > v) v = ((to - v) <= 8'd4) ? to : v + 8'd4;
      else        v = ((v - to) <= 8'd4) ? to : v - 8'd4;
      q_upd_s.push_back({ch, v});
    end
  endtask

  task automatic write_ch(input logic [7:0] ch, input logic [7:0] data);
    q_frm_b.push_back(2'b10);
    q_frm_s.push_back(2'b10);
    push_upd(ch, exp_tgt[ch[2:0]], data);
    exp_tgt[ch[2:0]] = data;
    send_frame({16'h0, ch, data}, 16);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (q_upd_b.size() + q_upd_s.size() + q_frm_b.size() + q_frm_s.size() == 0) break;
      wait_clk(1);
    end
    chk(tag, q_upd_b.size() + q_upd_s.size() + q_frm_b.size() + q_frm_s.size(), 0);
  endtask

  function automatic logic [63:0] exp_vec();
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = exp_tgt[c];
    return v;
  endfunction

  task automatic chk_outs(input string tag);
    chk({tag, "_b"}, bus_b.ctrl_out, exp_vec());
    chk({tag, "_s"}, bus_s.ctrl_out, exp_vec());
  endtask

  initial begin
    int n0_b, n0_s;
    for (int c = 0; c < 8; c++) exp_tgt[c] = 8'h80;

    wait_clk(4);
    chk("rst_out_b", bus_b.ctrl_out, 64'h8080808080808080);
    chk("rst_out_s", bus_s.ctrl_out, 64'h8080808080808080);
    chk("rst_upd_b", bus_b.ctrl_upd, 0);
    chk("rst_upd_s", bus_s.ctrl_upd, 0);
    chk("rst_strb_b", {bus_b.frame_ok, bus_b.frame_err}, 0);
    chk("rst_strb_s", {bus_s.frame_ok, bus_s.frame_err}, 0);
    reset = 1'b0;
    wait_clk(10);

    // Bypass latency: output follows one cycle after frame_ok.
    write_ch(8'h02, 8'hFF);
    drain("drain_ch2", 800);
    chk("byp_latency", upd_cyc_b[2] - ok_cyc_b, 1);
    chk_outs("out_ch2");

    upd0_cyc.delete();
    write_ch(8'h00, 8'h8E);
    drain("drain_ch0", 300);
    wait_clk(50);
    chk("slew_steps", upd0_cyc.size(), 4);
    if (upd0_cyc.size() == 4)
      for (int k = 1; k < 4; k++) chk("slew_spacing", upd0_cyc[k] - upd0_cyc[k-1], 10);
    chk_outs("out_ch0");

    write_ch(8'h05, 8'h02);
    drain("drain_ch5a", 800);
    write_ch(8'h05, 8'h00);
    drain("drain_ch5b", 200);
    chk("floor_s", bus_s.ctrl_out[5*8 +: 8], 8'h00);
    write_ch(8'h05, 8'hFC);
    drain("drain_ch5c", 1200);
    write_ch(8'h05, 8'hFE);
    drain("drain_ch5d", 200);
    write_ch(8'h05, 8'hFF);
    drain("drain_ch5e", 200);
    chk("ceil_s", bus_s.ctrl_out[5*8 +: 8], 8'hFF);
    chk_outs("out_ch5");

    n0_b = frm_cnt_b;
    n0_s = frm_cnt_s;
    q_frm_b.push_back(2'b01);
    q_frm_s.push_back(2'b01);
    send_frame(32'h0855, 16);
    drain("drain_badaddr", 100);
    wait_clk(30);
    chk("badaddr_cnt_b", frm_cnt_b - n0_b, 1);
    chk("badaddr_cnt_s", frm_cnt_s - n0_s, 1);
    chk_outs("out_badaddr");

    q_frm_b.push_back(2'b01);
    q_frm_s.push_back(2'b01);
    send_frame(32'h0099, 15);
    q_frm_b.push_back(2'b01);
    q_frm_s.push_back(2'b01);
    send_frame(32'h0267, 17);
    drain("drain_badlen", 100);
    wait_clk(30);
    chk_outs("out_badlen");
    write_ch(8'h01, 8'h33);
    drain("drain_ch1", 400);
    chk_outs("out_ch1");

    // Reset lands mid-frame; the tail of that frame must be ignored.
    n0_b = frm_cnt_b;
    n0_s = frm_cnt_s;
    ss_n = 1'b0;
    wait_clk(5);
    clk_bits(32'h01, 7);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) exp_tgt[c] = 8'h80;
    clk_bits(32'h190, 9);
    wait_clk(5);
    ss_n = 1'b1;
    wait_clk(30);
    chk("midrst_cnt_b", frm_cnt_b - n0_b, 0);
    chk("midrst_cnt_s", frm_cnt_s - n0_s, 0);
    chk_outs("out_midrst");
    write_ch(8'h03, 8'h90);
    drain("drain_ch3", 200);
    chk_outs("out_ch3");

    wait_clk(20);
    chk("queues_empty", q_upd_b.size() + q_upd_s.size() + q_frm_b.size() + q_frm_s.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
